// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: bus widths, reset PC, PC stride and the
// {pc, insn} entry stored in the instruction queue.
package cpu_pkg;

  localparam int INSN_W = 32;
  localparam int ADDR_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] PC_STEP          = 32'd4;

  // One queued instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INSN_W-1:0] insn;
  } ifq_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch front-end bus: ROM read port, branch redirect, halt and the
// valid/ready instruction stream towards the decoder.
interface fetch_queue_if;
  import cpu_pkg::*;

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [INSN_W-1:0] imem_data;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halt;
  logic              ins_valid;
  logic              ins_ready;
  logic [INSN_W-1:0] ins;
  logic [ADDR_W-1:0] ins_pc;

  // Fetch unit side.
  modport master (
    output imem_req, imem_addr, ins_valid, ins, ins_pc,
    input  imem_data, redirect, redirect_pc, halt, ins_ready
  );

  // Environment side: ROM, branch unit and decoder.
  modport slave (
    input  imem_req, imem_addr, ins_valid, ins, ins_pc,
    output imem_data, redirect, redirect_pc, halt, ins_ready
  );

endinterface

// File: rtl/ifq_fifo.sv
// Instruction queue: shift-style FIFO of {pc, insn} entries whose head slot
// and valid flag are registers, so the decoder sees no combinational path.
module ifq_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rstd,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  input  ifq_entry_t                   wdata_i,
  output ifq_entry_t                   head_o,
  output logic                         head_valid_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  ifq_entry_t       ent_q [DEPTH];
  ifq_entry_t       ent_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;

  // Next queue contents: flush wins, otherwise shift on pop and append on push.
  always_comb begin
    ent_d   = ent_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      case ({push_i, pop_i})
        2'b01: begin
          for (int i = 0; i < DEPTH - 1; i++) begin
            ent_d[i] = ent_q[i+1];
          end
          count_d = count_q - CNT_W'(1);
        end
        2'b10: begin
          for (int i = 0; i < DEPTH; i++) begin
            if (count_q == CNT_W'(i)) begin
              ent_d[i] = wdata_i;
            end else begin
              ent_d[i] = ent_q[i];
            end
          end
          count_d = count_q + CNT_W'(1);
        end
        2'b11: begin
          // Head leaves while the new word lands in the last occupied slot.
          for (int i = 0; i < DEPTH - 1; i++) begin
            ent_d[i] = ent_q[i+1];
          end
          for (int i = 0; i < DEPTH; i++) begin
            if (count_q == CNT_W'(i + 1)) begin
              ent_d[i] = wdata_i;
            end else begin
              ent_d[i] = ent_d[i];
            end
          end
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end
    valid_d = (count_d != '0);
  end

  // Queue storage, occupancy and registered head-valid flag.
  always_ff @(posedge clk or posedge rstd) begin
    if (rstd) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      ent_q   <= ent_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  assign head_o       = ent_q[0];
  assign head_valid_o = valid_q;
  assign count_o      = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues single-cycle ROM reads,
// tags returning words with their PC and queues them for the decoder.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int                DEPTH    = 2
) (
  input  logic          clk,
  input  logic          rstd,
  fetch_queue_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] tag_q, tag_d;
  logic              inflight_q, inflight_d;
  logic              squash_q, squash_d;

  logic              issue_s, pop_s, push_s;
  logic [OCC_W-1:0]  occ_s;
  logic [CNT_W-1:0]  count_s;
  ifq_entry_t        head_s;
  ifq_entry_t        push_data_s;
  logic              head_valid_s;

  // Handshake decode: pop, issue (room counts the word in flight) and push.
  always_comb begin
    pop_s   = head_valid_s & bus.ins_ready;
    occ_s   = {1'b0, count_s} + {{CNT_W{1'b0}}, inflight_q} - {{CNT_W{1'b0}}, pop_s};
    issue_s = !rstd && !bus.halt && !bus.redirect && (occ_s < OCC_W'(DEPTH));
    // A word returning in a redirect cycle belongs to the abandoned path.
    push_s  = inflight_q && !squash_q && !bus.redirect;
    push_data_s = '{pc: tag_q, insn: bus.imem_data};
  end

  // PC, tag, in-flight and squash next state; redirect overrides sequential fetch.
  always_comb begin
    if (bus.redirect) begin
      pc_d = align_pc(bus.redirect_pc);
    end else if (issue_s) begin
      pc_d = pc_q + PC_STEP;
    end else begin
      pc_d = pc_q;
    end

    if (issue_s) begin
      tag_d = pc_q;
    end else begin
      tag_d = tag_q;
    end

    inflight_d = issue_s;

    // A fresh issue always starts clean; a redirect marks any outstanding read stale.
    if (issue_s) begin
      squash_d = 1'b0;
    end else if (bus.redirect) begin
      squash_d = inflight_q;
    end else begin
      squash_d = squash_q;
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk or posedge rstd) begin
    if (rstd) begin
      pc_q       <= RESET_PC;
      tag_q      <= '0;
      inflight_q <= 1'b0;
      squash_q   <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      squash_q   <= squash_d;
    end
  end

  ifq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rstd         (rstd),
    .push_i       (push_s),
    .pop_i        (pop_s),
    .flush_i      (bus.redirect),
    .wdata_i      (push_data_s),
    .head_o       (head_s),
    .head_valid_o (head_valid_s),
    .count_o      (count_s)
  );

  assign bus.imem_req  = issue_s;
  assign bus.imem_addr = pc_q;
  assign bus.ins_valid = head_valid_s;
  assign bus.ins       = head_s.insn;
  assign bus.ins_pc    = head_s.pc;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a transaction-level model (queue of fetched PCs with
// the cycle each becomes visible) predicts imem_req/imem_addr and the decoder
// stream every cycle; a second instance checks PC wrap-around.
module tb_fetch_queue;
  import cpu_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC1  = 32'hFFFF_FFF8;

  logic clk  = 1'b0;
  logic rstd = 1'b1;

  always #5 clk = ~clk;

  fetch_queue_if ifc0 ();
  fetch_queue_if ifc1 ();

  fetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut0 (
    .clk  (clk),
    .rstd (rstd),
    .bus  (ifc0)
  );

  fetch_queue #(.RESET_PC(RPC1), .DEPTH(DEPTH)) dut1 (
    .clk  (clk),
    .rstd (rstd),
    .bus  (ifc1)
  );

  typedef struct {
    logic [31:0] pc;
    int          avail;
  } exp_t;

  exp_t        q[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          rel1     = 0;
  int          n_del0   = 0;
  int          n_del1   = 0;
  logic [31:0] exp_fetch  = 32'h0;
  logic [31:0] exp1_pc    = RPC1;
  logic [31:0] exp1_fetch = RPC1;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: inputs were set at the preceding negedge.
  task automatic cycle();
    logic        ev;
    logic        er;
    logic        pop;
    logic        req0;
    logic        req1;
    logic [31:0] a0;
    logic [31:0] a1;
    #1;
    req0 = ifc0.imem_req;
    a0   = ifc0.imem_addr;
    req1 = ifc1.imem_req;
    a1   = ifc1.imem_addr;
    if (rstd) begin
      check("rst_ins_valid", ifc0.ins_valid, 32'd0);
      check("rst_imem_req", req0, 32'd0);
      check("rst_ins", ifc0.ins, 32'd0);
      check("rst_ins_pc", ifc0.ins_pc, 32'd0);
      check("rst_imem_req1", req1, 32'd0);
      q.delete();
      exp_fetch  = 32'h0;
      exp1_pc    = RPC1;
      exp1_fetch = RPC1;
      rel1       = 0;
    end else begin
      ev  = (q.size() > 0) && (q[0].avail <= cyc);
      pop = ev && ifc0.ins_ready;
      check("ins_valid", ifc0.ins_valid, {31'b0, ev});
      if (ev) begin
        check("ins_pc", ifc0.ins_pc, q[0].pc);
        check("ins", ifc0.ins, rom(q[0].pc));
      end
      er = !ifc0.halt && !ifc0.redirect && ((q.size() - (pop ? 1 : 0)) < DEPTH);
      check("imem_req", req0, {31'b0, er});
      if (er) check("imem_addr", a0, exp_fetch);
      if (ifc0.redirect) begin
        q.delete();
        exp_fetch = ifc0.redirect_pc & 32'hFFFF_FFFC;
      end else begin
        if (pop) begin
          void'(q.pop_front());
          n_del0++;
        end
        if (er) begin
          q.push_back('{pc: exp_fetch, avail: cyc + 2});
          exp_fetch += 32'd4;
        end
      end
      // Free-running instance: one request per cycle, stream starts 2 cycles in.
      check("wrap_req", req1, 32'd1);
      check("wrap_addr", a1, exp1_fetch);
      exp1_fetch += 32'd4;
      check("wrap_valid", ifc1.ins_valid, (rel1 >= 2) ? 32'd1 : 32'd0);
      if (rel1 >= 2) begin
        check("wrap_ins_pc", ifc1.ins_pc, exp1_pc);
        check("wrap_ins", ifc1.ins, rom(exp1_pc));
        exp1_pc += 32'd4;
        n_del1++;
      end
      rel1++;
    end
    @(posedge clk);
    #1;
    if (req0) ifc0.imem_data = rom(a0);
    if (req1) ifc1.imem_data = rom(a1);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ifc0.ins_ready   = 1'b0;
    ifc0.halt        = 1'b0;
    ifc0.redirect    = 1'b0;
    ifc0.redirect_pc = 32'h0;
    ifc0.imem_data   = 32'h0;
    ifc1.ins_ready   = 1'b1;
    ifc1.halt        = 1'b0;
    ifc1.redirect    = 1'b0;
    ifc1.redirect_pc = 32'h0;
    ifc1.imem_data   = 32'h0;
    rstd = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state.
    repeat (2) cycle();

    // Free-running fetch from RESET_PC.
    rstd = 1'b0;
    ifc0.ins_ready = 1'b1;
    repeat (10) cycle();

    // Backpressure: queue fills to DEPTH and requests stop.
    ifc0.ins_ready = 1'b0;
    repeat (5) cycle();
    ifc0.ins_ready = 1'b1;
    repeat (8) cycle();

    // Redirect to an unaligned target with a read in flight.
    ifc0.redirect    = 1'b1;
    ifc0.redirect_pc = 32'h0000_0103;
    cycle();
    ifc0.redirect = 1'b0;
    repeat (8) cycle();

    // Halt with a read outstanding, then resume.
    ifc0.halt = 1'b1;
    repeat (4) cycle();
    ifc0.halt = 1'b0;
    repeat (6) cycle();

    // Redirect while halted: PC moves, nothing is fetched until release.
    ifc0.halt = 1'b1;
    cycle();
    ifc0.redirect    = 1'b1;
    ifc0.redirect_pc = 32'h0000_0200;
    cycle();
    ifc0.redirect = 1'b0;
    repeat (2) cycle();
    ifc0.halt = 1'b0;
    repeat (6) cycle();

    // Reset mid-stream with a full queue.
    ifc0.ins_ready = 1'b0;
    repeat (4) cycle();
    rstd = 1'b1;
    repeat (2) cycle();
    rstd = 1'b0;
    ifc0.ins_ready = 1'b1;
    repeat (8) cycle();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      ifc0.ins_ready   = ($urandom_range(0, 3) != 0);
      ifc0.halt        = ($urandom_range(0, 9) == 0) ? ~ifc0.halt : ifc0.halt;
      ifc0.redirect    = ($urandom_range(0, 15) == 0);
      ifc0.redirect_pc = $urandom;
      cycle();
    end
    ifc0.redirect = 1'b0;
    ifc0.halt     = 1'b0;
    ifc0.ins_ready = 1'b1;
    repeat (6) cycle();

    check("progress0", (n_del0 > 60) ? 32'd1 : 32'd0, 32'd1);
    check("progress1", (n_del1 > 60) ? 32'd1 : 32'd0, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction-fetch front end feeding the decoder. Owns the program counter, issues reads to the synchronous instruction ROM, and buffers returned words with their PCs in a small queue. Presents them to the decoder over a valid/ready handshake. Supports branch redirect with squash of stale fetches, and a level-sensitive halt.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; low 2 bits must be 0.
- `DEPTH`, default 2: instruction-queue entries; must be at least 2.

Ports:
- `clk` input 1: single clock, rising edge.
- `rstd` input 1: reset, asynchronous, active-high.
- `imem_req` output 1: ROM read issued this cycle.
- `imem_addr` output 32: ROM byte address, equal to the current PC.
- `imem_data` input 32: ROM read data, valid the cycle after `imem_req`.
- `redirect` input 1: one-cycle pulse, taken branch or jump.
- `redirect_pc` input 32: new PC; bits [1:0] are ignored and treated as 0.
- `halt` input 1: level signal; while high, no new reads are issued.
- `ins_valid` output 1: queue head is valid.
- `ins_ready` input 1: decoder accepts the head this cycle.
- `ins` output 32: instruction word at the head.
- `ins_pc` output 32: PC of the head word.

## Operation
- State:
  - `pc` (32 bits)
  - `count` (0..DEPTH, occupancy)
  - `inflight` (0/1, read outstanding)
  - `squash` (0/1, marks the outstanding read as stale)
  - FIFO of {pc, word} pairs
- Pop: `ins_valid && ins_ready` pops the head.
- Issue condition: `!rstd && !halt && !redirect && (count + inflight - pop) < DEPTH`.
  - On issue: `imem_req=1`, `imem_addr=pc`, then `pc <= pc+4`, which wraps modulo 2^32.
  - The tag PC is held in a register for the returning word.
- Return: in the cycle after an issue, `imem_data` is pushed together with its tag PC, unless `squash` is set or a `redirect` occurs that same cycle.
- Redirect has the highest priority, and every effect lands at the clock edge:
  - the FIFO is flushed (`count <= 0`);
  - `pc <= {redirect_pc[31:2], 2'b00}`;
  - if a read is in flight or is returning, `squash <= 1` and that word is discarded;
  - no issue occurs in the redirect cycle.
- Halt:
  - Already-issued reads still complete and are pushed.
  - The queue keeps draining to the decoder.
  - Deasserting halt resumes fetching at the held `pc`.
  - Redirect during halt updates `pc` without issuing a read.
- Simultaneous push and pop with `count == DEPTH` is legal. The issue condition prevents any push into a full queue without a matching pop.
- Reset mid-operation discards all queued and in-flight data; the ROM word from a pre-reset request is ignored.

## Timing
- Reset values: `pc=RESET_PC`, `count=0`, `inflight=0`, `squash=0`, `ins_valid=0`, `ins=0`, `ins_pc=0`, `imem_req=0`.
- `imem_req` is combinational from state and inputs, and is forced to 0 while `rstd` is high.
- Fetch-to-decode latency:
  - request in cycle N;
  - data captured at the end of N+1;
  - `ins_valid=1` in N+2.
- Throughput: one instruction per cycle while the decoder holds `ins_ready=1`.
- First request occurs in the first cycle after `rstd` falls, with `imem_addr=RESET_PC`.
- After a redirect in cycle R:
  - `ins_valid=0` in R+1;
  - first request at the target in R+1;
  - first target instruction valid in R+3.
- Outputs `ins`, `ins_pc` and `ins_valid` come straight from registers, with no combinational path from `ins_ready`.
- `imem_req` depends combinationally on `ins_ready`, `halt` and `redirect`.

## Structure
- Shared package `cpu_pkg`:
  - `INSN_W=32`, `ADDR_W=32`;
  - default `RESET_PC`;
  - `PC_STEP=4`.
- Sub-module `ifq_fifo`:
  - synchronous FIFO of width 64 ({pc, insn}) and depth `DEPTH`;
  - push, pop and flush inputs, with flush taking priority;
  - registered head outputs;
  - same `clk`/`rstd` convention.
- `fetch_queue` holds the PC, issue logic, tag register and squash tracking.

## Test plan
- Reset then `ins_ready=1`, with a ROM model returning `mem[addr]`:
  - requests at 0x0, 0x4, 0x8, ...;
  - `ins_valid` first rises 2 cycles after reset release with `ins_pc=0`;
  - thereafter one instruction per cycle.
- Backpressure, holding `ins_ready=0` for 5 cycles:
  - exactly `DEPTH` words are queued and `imem_req` drops;
  - on release, the words appear in order with no duplicate or lost PC.
- Redirect to 0x103 while a read is in flight:
  - the stale word is never presented;
  - the next `ins_pc` is 0x100, valid 3 cycles after the redirect.
- Halt asserted with a read outstanding:
  - that word is still delivered and no new `imem_req` occurs;
  - on deassert, fetching resumes at the next sequential PC.
- `RESET_PC=32'hFFFF_FFF8`, free-running: PCs go 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000, wrapping cleanly.
- Assert `rstd` mid-stream with a full queue:
  - `ins_valid=0` immediately (asynchronously);
  - fetch restarts at `RESET_PC` after release;
  - the pre-reset ROM data is ignored.
